// File: rtl/taxi_eth_baser_pkg.sv
// Shared 10GBASE-R definitions: sync header codes and the block-lock state set.
package taxi_eth_baser_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        LOCKED    = 2'd1,
        SLIP_HIGH = 2'd2,
        SLIP_HOLD = 2'd3
    } baser_sync_state_t;

    // A header is good only if it is one of the two legal transition codes.
    function automatic logic sync_hdr_ok(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/taxi_eth_phy_10g_rx_frame_sync_if.sv
// SERDES RX header channel between the gearbox and the frame-sync block.
//
// Handshake: serdes_rx_hdr is meaningful only on cycles where
// serdes_rx_hdr_valid=1 (gap cycles carry no header); there is no
// backpressure. serdes_rx_bitslip flows the other way as a level request
// asking the gearbox to shift the block boundary by one bit.
interface taxi_eth_phy_10g_rx_frame_sync_if #(
    parameter int HDR_W = 2
) ();
    logic [HDR_W-1:0] serdes_rx_hdr;
    logic             serdes_rx_hdr_valid;
    logic             serdes_rx_bitslip;

    // SERDES/gearbox side
    modport master (
        output serdes_rx_hdr,
        output serdes_rx_hdr_valid,
        input  serdes_rx_bitslip
    );

    // Frame-sync side
    modport slave (
        input  serdes_rx_hdr,
        input  serdes_rx_hdr_valid,
        output serdes_rx_bitslip
    );
endinterface

// File: rtl/taxi_eth_phy_10g_rx_frame_sync.sv
// 64b/66b block-lock FSM: slips the gearbox until 64 good sync headers in a
// row are seen, then holds lock until 16 bad headers land in one 64-header
// window.
module taxi_eth_phy_10g_rx_frame_sync
    import taxi_eth_baser_pkg::*;
#(
    parameter int HDR_W               = 2,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    taxi_eth_phy_10g_rx_frame_sync_if.slave        serdes,
    output logic                                   rx_block_lock,
    output logic                                   rx_sh_invalid,
    output baser_sync_state_t                      dbg_state
);

    if (HDR_W != 2) begin : g_bad_hdr_w
        $fatal(1, "HDR_W must be 2");
    end
    if (BITSLIP_HIGH_CYCLES < 1 || BITSLIP_HIGH_CYCLES > 255) begin : g_bad_high
        $fatal(1, "BITSLIP_HIGH_CYCLES must be 1..255");
    end
    if (BITSLIP_LOW_CYCLES < 0 || BITSLIP_LOW_CYCLES > 255) begin : g_bad_low
        $fatal(1, "BITSLIP_LOW_CYCLES must be 0..255");
    end

    localparam logic [7:0] SLIP_HIGH_INIT = 8'(BITSLIP_HIGH_CYCLES - 1);
    localparam logic [7:0] SLIP_LOW_INIT  = 8'(BITSLIP_LOW_CYCLES);
    localparam logic [6:0] SH_LAST        = 7'd63;  // 64th header of a window
    localparam logic [4:0] INV_LAST       = 5'd15;  // 16th invalid header

    baser_sync_state_t state_q, state_d;
    logic [6:0] sh_cnt_q, sh_cnt_d;
    logic [4:0] sh_invalid_cnt_q, sh_invalid_cnt_d;
    logic [7:0] slip_cnt_q, slip_cnt_d;
    logic       bitslip_q, bitslip_d;
    logic       lock_q, lock_d;
    logic       sh_invalid_q, sh_invalid_d;

    logic hdr_ok;
    assign hdr_ok = sync_hdr_ok(serdes.serdes_rx_hdr);

    // Next-state: classify headers in UNLOCKED/LOCKED, time the slip phases.
    always_comb begin
        state_d          = state_q;
        sh_cnt_d         = sh_cnt_q;
        sh_invalid_cnt_d = sh_invalid_cnt_q;
        slip_cnt_d       = slip_cnt_q;
        bitslip_d        = bitslip_q;
        lock_d           = lock_q;
        sh_invalid_d     = 1'b0;

        case (state_q)
            UNLOCKED: begin
                if (serdes.serdes_rx_hdr_valid) begin
                    if (hdr_ok) begin
                        if (sh_cnt_q == SH_LAST) begin
                            state_d          = LOCKED;
                            lock_d           = 1'b1;
                            sh_cnt_d         = '0;
                            sh_invalid_cnt_d = '0;
                        end else begin
                            sh_cnt_d = sh_cnt_q + 7'd1;
                        end
                    end else begin
                        sh_invalid_d     = 1'b1;
                        state_d          = SLIP_HIGH;
                        bitslip_d        = 1'b1;
                        slip_cnt_d       = SLIP_HIGH_INIT;
                        sh_cnt_d         = '0;
                        sh_invalid_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (serdes.serdes_rx_hdr_valid) begin
                    sh_invalid_d = !hdr_ok;
                    // The 16th bad header wins even if it also closes the window.
                    if (!hdr_ok && sh_invalid_cnt_q == INV_LAST) begin
                        state_d          = SLIP_HIGH;
                        lock_d           = 1'b0;
                        bitslip_d        = 1'b1;
                        slip_cnt_d       = SLIP_HIGH_INIT;
                        sh_cnt_d         = '0;
                        sh_invalid_cnt_d = '0;
                    end else if (sh_cnt_q == SH_LAST) begin
                        sh_cnt_d         = '0;
                        sh_invalid_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_q + 7'd1;
                        if (!hdr_ok) begin
                            sh_invalid_cnt_d = sh_invalid_cnt_q + 5'd1;
                        end
                    end
                end
            end
            SLIP_HIGH: begin
                lock_d = 1'b0;
                if (slip_cnt_q == 8'd0) begin
                    bitslip_d = 1'b0;
                    if (BITSLIP_LOW_CYCLES == 0) begin
                        state_d = UNLOCKED;
                    end else begin
                        state_d    = SLIP_HOLD;
                        slip_cnt_d = SLIP_LOW_INIT;
                    end
                end else begin
                    slip_cnt_d = slip_cnt_q - 8'd1;
                end
            end
            SLIP_HOLD: begin
                // Hold-off counts cycles, not headers; leave after exactly
                // BITSLIP_LOW_CYCLES cycles in this state.
                if (slip_cnt_q <= 8'd1) begin
                    state_d    = UNLOCKED;
                    slip_cnt_d = '0;
                end else begin
                    slip_cnt_d = slip_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = UNLOCKED;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= UNLOCKED;
            sh_cnt_q         <= '0;
            sh_invalid_cnt_q <= '0;
            slip_cnt_q       <= '0;
            bitslip_q        <= 1'b0;
            lock_q           <= 1'b0;
            sh_invalid_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            sh_cnt_q         <= sh_cnt_d;
            sh_invalid_cnt_q <= sh_invalid_cnt_d;
            slip_cnt_q       <= slip_cnt_d;
            bitslip_q        <= bitslip_d;
            lock_q           <= lock_d;
            sh_invalid_q     <= sh_invalid_d;
        end
    end

    assign serdes.serdes_rx_bitslip = bitslip_q;
    assign rx_block_lock            = lock_q;
    assign rx_sh_invalid            = sh_invalid_q;
    assign dbg_state                = state_q;

endmodule

// File: tb/tb_taxi_eth_phy_10g_rx_frame_sync.sv
// Bench for the block-lock FSM: two instances (default slip timing, and
// 3-cycle slip with no hold-off) share one stimulus stream and are each
// checked against a timestamp-based reference model plus directed checks.
module tb_taxi_eth_phy_10g_rx_frame_sync;
    import taxi_eth_baser_pkg::*;

    localparam int H_A = 1;
    localparam int L_A = 8;
    localparam int H_B = 3;
    localparam int L_B = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    taxi_eth_phy_10g_rx_frame_sync_if #(.HDR_W(2)) if_a ();
    taxi_eth_phy_10g_rx_frame_sync_if #(.HDR_W(2)) if_b ();

    logic lock_a, inv_a, lock_b, inv_b;
    baser_sync_state_t dbg_a, dbg_b;

    taxi_eth_phy_10g_rx_frame_sync #(
        .HDR_W(2), .BITSLIP_HIGH_CYCLES(H_A), .BITSLIP_LOW_CYCLES(L_A)
    ) dut_a (
        .clk(clk), .rst(rst), .serdes(if_a),
        .rx_block_lock(lock_a), .rx_sh_invalid(inv_a), .dbg_state(dbg_a)
    );

    taxi_eth_phy_10g_rx_frame_sync #(
        .HDR_W(2), .BITSLIP_HIGH_CYCLES(H_B), .BITSLIP_LOW_CYCLES(L_B)
    ) dut_b (
        .clk(clk), .rst(rst), .serdes(if_b),
        .rx_block_lock(lock_b), .rx_sh_invalid(inv_b), .dbg_state(dbg_b)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    longint cyc = 0;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each instance is described by: lock flag, header/bad counts in the
    // current window (1-based), the last edge index after which bitslip is
    // still high, and the first edge index at which headers count again.
    int     p_high [2] = '{H_A, H_B};
    int     p_low  [2] = '{L_A, L_B};
    bit     m_locked [2] = '{1'b0, 1'b0};
    int     m_win    [2] = '{0, 0};
    int     m_bad    [2] = '{0, 0};
    longint m_resume [2] = '{0, 0};
    longint m_bs_last[2] = '{-1, -1};
    bit     exp_bs   [2];
    bit     exp_lock [2];
    bit     exp_inv  [2];

    function automatic void model_slip(input int d);
        m_win[d]     = 0;
        m_bad[d]     = 0;
        m_bs_last[d] = cyc + p_high[d] - 1;
        m_resume[d]  = cyc + p_high[d] + p_low[d] + 1;
    endfunction

    function automatic void model_update(input int d, input bit r, input logic [1:0] h, input bit v);
        bit bad;
        bad = (h == 2'b00) || (h == 2'b11);
        exp_inv[d] = 1'b0;
        if (r) begin
            m_locked[d]  = 1'b0;
            m_win[d]     = 0;
            m_bad[d]     = 0;
            m_resume[d]  = cyc + 1;
            m_bs_last[d] = -1;
        end else if (v && cyc >= m_resume[d]) begin
            if (!m_locked[d]) begin
                if (bad) begin
                    exp_inv[d] = 1'b1;
                    model_slip(d);
                end else begin
                    m_win[d]++;
                    if (m_win[d] == 64) begin
                        m_locked[d] = 1'b1;
                        m_win[d]    = 0;
                    end
                end
            end else begin
                m_win[d]++;
                if (bad) begin
                    m_bad[d]++;
                    exp_inv[d] = 1'b1;
                end
                if (m_bad[d] == 16) begin
                    m_locked[d] = 1'b0;
                    model_slip(d);
                end else if (m_win[d] == 64) begin
                    m_win[d] = 0;
                    m_bad[d] = 0;
                end
            end
        end
        exp_bs[d]   = (cyc <= m_bs_last[d]);
        exp_lock[d] = m_locked[d];
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit r, input logic [1:0] h, input bit v);
        rst = r;
        if_a.serdes_rx_hdr = h;
        if_a.serdes_rx_hdr_valid = v;
        if_b.serdes_rx_hdr = h;
        if_b.serdes_rx_hdr_valid = v;
        @(posedge clk);
        cyc++;
        model_update(0, r, h, v);
        model_update(1, r, h, v);
        #1;
        chk("model_bitslip_a", if_a.serdes_rx_bitslip, exp_bs[0]);
        chk("model_lock_a", lock_a, exp_lock[0]);
        chk("model_shinv_a", inv_a, exp_inv[0]);
        chk("model_bitslip_b", if_b.serdes_rx_bitslip, exp_bs[1]);
        chk("model_lock_b", lock_b, exp_lock[1]);
        chk("model_shinv_b", inv_b, exp_inv[1]);
    endtask

    // ---------------- directed vector table (instance A) ----------------
    typedef struct {
        bit         rst;
        logic [1:0] hdr;
        bit         vld;
        int         reps;
        bit         e_lock;
        bit         e_bs;
        bit         e_inv;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input logic [1:0] h, input bit v, input int n,
                                input bit el, input bit eb, input bit ei);
        vec_t e;
        e = '{rst: r, hdr: h, vld: v, reps: n, e_lock: el, e_bs: eb, e_inv: ei};
        tbl.push_back(e);
    endfunction

    initial begin
        int pulses;
        int nbad;
        int nv;
        int phase_rate;
        bit v;
        bit bad;
        bit r;
        logic [1:0] h;

        if_a.serdes_rx_hdr = 2'b00;
        if_a.serdes_rx_hdr_valid = 1'b0;
        if_b.serdes_rx_hdr = 2'b00;
        if_b.serdes_rx_hdr_valid = 1'b0;

        // Reset, then lock after exactly 64 good headers.
        add(1, 2'b01, 0, 2,  0, 0, 0);
        add(0, 2'b01, 1, 63, 0, 0, 0);
        add(0, 2'b01, 1, 1,  1, 0, 0);
        add(0, 2'b10, 1, 10, 1, 0, 0);
        // Unlocked: 10 good, one bad -> slip 1 cycle, 8 hold-off, then relock.
        add(1, 2'b01, 0, 1,  0, 0, 0);
        add(0, 2'b01, 1, 10, 0, 0, 0);
        add(0, 2'b00, 1, 1,  0, 1, 1);
        add(0, 2'b00, 1, 9,  0, 0, 0);  // slip-high edge + 8 hold-off: all ignored
        add(0, 2'b01, 1, 63, 0, 0, 0);
        add(0, 2'b01, 1, 1,  1, 0, 0);

        foreach (tbl[i]) begin
            for (int j = 0; j < tbl[i].reps; j++) begin
                step(tbl[i].rst, tbl[i].hdr, tbl[i].vld);
                chk("tbl_lock_a", lock_a, tbl[i].e_lock);
                chk("tbl_bitslip_a", if_a.serdes_rx_bitslip, tbl[i].e_bs);
                chk("tbl_shinv_a", inv_a, tbl[i].e_inv);
            end
        end

        // Locked window with 15 bad headers keeps lock.
        pulses = 0;
        nbad = 0;
        for (int i = 0; i < 64; i++) begin
            bad = (i % 4 == 1) && (nbad < 15);
            if (bad) nbad++;
            step(0, bad ? 2'b11 : 2'b10, 1);
            if (inv_a) pulses++;
            chk("win15_lock_a", lock_a, 1'b1);
        end
        chk_int("win15_pulses_a", pulses, 15);

        // Next window: 16th bad header drops lock and raises bitslip together.
        nbad = 0;
        for (int i = 0; i < 31; i++) begin
            bad = (i % 2 == 0);
            if (bad) nbad++;
            step(0, bad ? 2'b11 : 2'b01, 1);
            chk("win16_lock_a", lock_a, nbad < 16);
            chk("win16_bitslip_a", if_a.serdes_rx_bitslip, nbad == 16);
        end
        for (int i = 0; i < 10; i++) step(0, 2'b01, 1);

        // Instance B: 3-cycle slip, no hold-off, immediate re-slip.
        step(1, 2'b01, 1);
        for (int i = 0; i < 5; i++) step(0, 2'b01, 1);
        step(0, 2'b00, 1);
        chk("b_slip_bitslip1", if_b.serdes_rx_bitslip, 1'b1);
        chk("b_slip_shinv", inv_b, 1'b1);
        step(0, 2'b00, 1);
        chk("b_slip_bitslip2", if_b.serdes_rx_bitslip, 1'b1);
        chk("b_slip_ignored", inv_b, 1'b0);
        step(0, 2'b00, 1);
        chk("b_slip_bitslip3", if_b.serdes_rx_bitslip, 1'b1);
        step(0, 2'b00, 1);
        chk("b_slip_fall", if_b.serdes_rx_bitslip, 1'b0);
        chk("b_slip_fall_shinv", inv_b, 1'b0);
        step(0, 2'b00, 1);
        chk("b_reslip_bitslip", if_b.serdes_rx_bitslip, 1'b1);
        chk("b_reslip_shinv", inv_b, 1'b1);

        // Gearbox gaps: valid 32 of every 33 cycles; lock on 64th valid header.
        step(1, 2'b10, 0);
        nv = 0;
        for (int i = 0; i < 70; i++) begin
            v = (i % 33) != 32;
            if (v) nv++;
            step(0, 2'b10, v);
            chk("gap_lock_a", lock_a, nv >= 64);
            chk("gap_lock_b", lock_b, nv >= 64);
        end

        // Reset during SLIP_HIGH, then during LOCKED.
        step(1, 2'b01, 1);
        step(0, 2'b00, 1);
        step(0, 2'b01, 1);
        step(1, 2'b01, 1);
        chk("rst_slip_bitslip_b", if_b.serdes_rx_bitslip, 1'b0);
        chk("rst_slip_lock_b", lock_b, 1'b0);
        chk("rst_slip_shinv_b", inv_b, 1'b0);
        for (int i = 0; i < 64; i++) begin
            step(0, 2'b01, 1);
            chk("relock1_lock_a", lock_a, i == 63);
            chk("relock1_lock_b", lock_b, i == 63);
            chk("relock1_bitslip_b", if_b.serdes_rx_bitslip, 1'b0);
        end
        step(1, 2'b11, 1);
        chk("rst_lock_lock_a", lock_a, 1'b0);
        chk("rst_lock_bitslip_a", if_a.serdes_rx_bitslip, 1'b0);
        chk("rst_lock_shinv_a", inv_a, 1'b0);
        for (int i = 0; i < 64; i++) begin
            step(0, 2'b10, 1);
            chk("relock2_lock_a", lock_a, i == 63);
        end

        // Randomized traffic with varying bad-header density.
        step(1, 2'b01, 0);
        for (int i = 0; i < 3000; i++) begin
            case ((i / 400) % 3)
                0:       phase_rate = 200;
                1:       phase_rate = 10;
                default: phase_rate = 3;
            endcase
            r = ($urandom_range(0, 1499) == 0);
            v = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, phase_rate - 1) == 0) begin
                h = $urandom_range(0, 1) ? 2'b11 : 2'b00;
            end else begin
                h = $urandom_range(0, 1) ? 2'b10 : 2'b01;
            end
            step(r, h, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
